// File: rtl/mdio_pkg.sv
// Shared constants, field widths and FSM state encoding for the MDIO responder.
package mdio_pkg;

  localparam int PHYAD_W      = 5;
  localparam int REGAD_W      = 5;
  localparam int DATA_W       = 16;
  localparam int OP_W         = 2;
  localparam int IGNORE_EDGES = 18;

  localparam logic [OP_W-1:0] OP_READ  = 2'b10;
  localparam logic [OP_W-1:0] OP_WRITE = 2'b01;

  typedef enum logic [3:0] {
    IDLE,
    START,
    OPCODE,
    PHYAD,
    REGAD,
    TA,
    RDATA,
    WDATA,
    IGNORE
  } mdio_state_e;

endpackage

// File: rtl/mdio_sync.sv
// Two-flop synchronizers for MDC and MDIO plus an MDC rising-edge detector.
module mdio_sync (
  input  logic clock,
  input  logic reset,
  input  logic mdc_pin,
  input  logic mdio_raw,
  output logic mdc_rise,
  output logic mdio_s
);

  // mdc_s[1:0] is the synchronizer, mdc_s[2] holds the previous synchronized level
  logic [2:0] mdc_s;
  logic [1:0] mdio_sr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mdc_s   <= '0;
      mdio_sr <= '0;
    end else begin
      mdc_s   <= {mdc_s[1:0], mdc_pin};
      mdio_sr <= {mdio_sr[0], mdio_raw};
    end
  end

  assign mdc_rise = mdc_s[1] & ~mdc_s[2];
  assign mdio_s   = mdio_sr[1];

endmodule

// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder: decodes frames from the station into register strobes.
// Build option: MDIO_PREAMBLE_SUPPRESS_EN accepts ST after a single preamble one.
module mdio_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR     = 5'h00,
  parameter int         PREAMBLE_LEN = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mdc_pin,
  inout  wire         mdio_pin,
  output logic [4:0]  reg_addr,
  output logic        reg_rd,
  input  logic [15:0] reg_rdata,
  output logic        reg_wr,
  output logic [15:0] reg_wdata,
  output logic        busy,
  output logic [3:0]  state_dbg
);

  localparam int PRE_W = $clog2(PREAMBLE_LEN + 1);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam int PRE_REQ = 1;
`else
  localparam int PRE_REQ = PREAMBLE_LEN;
`endif
  localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(PREAMBLE_LEN);
  localparam logic [PRE_W-1:0] PRE_NEED  = PRE_W'(PRE_REQ);

  logic mdc_rise, mdio_s;

  mdio_sync u_sync (
    .clock    (clock),
    .reset    (reset),
    .mdc_pin  (mdc_pin),
    .mdio_raw (mdio_pin),
    .mdc_rise (mdc_rise),
    .mdio_s   (mdio_s)
  );

  mdio_state_e        state, state_n;
  logic [PRE_W-1:0]   pre_cnt, pre_cnt_n;
  logic [4:0]         bit_cnt, bit_cnt_n;
  logic               op_hi, op_hi_n;
  logic [3:0]         phy_sh, phy_sh_n;
  logic               is_read, is_read_n;
  logic [4:0]         reg_addr_n;
  logic [15:0]        shreg, shreg_n;
  logic [15:0]        reg_wdata_n;
  logic               reg_rd_n, reg_wr_n;
  logic               rd_cap, rd_cap_n;
  logic               mdio_oe, mdio_oe_n;
  logic               mdio_out, mdio_out_n;
  logic               busy_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pre_cnt   <= '0;
      bit_cnt   <= '0;
      op_hi     <= 1'b0;
      phy_sh    <= '0;
      is_read   <= 1'b0;
      reg_addr  <= '0;
      shreg     <= '0;
      reg_wdata <= '0;
      reg_rd    <= 1'b0;
      reg_wr    <= 1'b0;
      rd_cap    <= 1'b0;
      mdio_oe   <= 1'b0;
      mdio_out  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      pre_cnt   <= pre_cnt_n;
      bit_cnt   <= bit_cnt_n;
      op_hi     <= op_hi_n;
      phy_sh    <= phy_sh_n;
      is_read   <= is_read_n;
      reg_addr  <= reg_addr_n;
      shreg     <= shreg_n;
      reg_wdata <= reg_wdata_n;
      reg_rd    <= reg_rd_n;
      reg_wr    <= reg_wr_n;
      rd_cap    <= rd_cap_n;
      mdio_oe   <= mdio_oe_n;
      mdio_out  <= mdio_out_n;
      busy      <= busy_n;
    end
  end

  always_comb begin
    state_n     = state;
    pre_cnt_n   = pre_cnt;
    bit_cnt_n   = bit_cnt;
    op_hi_n     = op_hi;
    phy_sh_n    = phy_sh;
    is_read_n   = is_read;
    reg_addr_n  = reg_addr;
    shreg_n     = shreg;
    reg_wdata_n = reg_wdata;
    reg_rd_n    = 1'b0;
    reg_wr_n    = 1'b0;
    rd_cap_n    = reg_rd;
    mdio_oe_n   = mdio_oe;
    mdio_out_n  = mdio_out;

    // Register file answers one clock after the strobe; latch it then.
    if (rd_cap) shreg_n = reg_rdata;

    if (mdc_rise) begin
      case (state)
        IDLE: begin
          if (mdio_s) begin
            if (pre_cnt != PRE_MAX) pre_cnt_n = pre_cnt + 1'b1;
          end else if (pre_cnt >= PRE_NEED) begin
            state_n = START;
          end else begin
            pre_cnt_n = '0;
          end
        end
        START: begin
          pre_cnt_n = '0;
          bit_cnt_n = '0;
          state_n   = mdio_s ? OPCODE : IDLE;
        end
        OPCODE: begin
          op_hi_n   = mdio_s;
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == 5'd1) begin
            bit_cnt_n = '0;
            case ({op_hi, mdio_s})
              OP_READ:  begin is_read_n = 1'b1; state_n = PHYAD; end
              OP_WRITE: begin is_read_n = 1'b0; state_n = PHYAD; end
              default:  state_n = IGNORE;
            endcase
          end
        end
        PHYAD: begin
          phy_sh_n  = {phy_sh[2:0], mdio_s};
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == 5'd4) begin
            bit_cnt_n = '0;
            state_n   = ({phy_sh, mdio_s} == PHY_ADDR) ? REGAD : IGNORE;
          end
        end
        REGAD: begin
          reg_addr_n = {reg_addr[3:0], mdio_s};
          bit_cnt_n  = bit_cnt + 5'd1;
          if (bit_cnt == 5'd4) begin
            bit_cnt_n = '0;
            reg_rd_n  = is_read;
            state_n   = TA;
          end
        end
        TA: begin
          if (is_read) begin
            mdio_oe_n  = 1'b1;
            mdio_out_n = 1'b0;
            bit_cnt_n  = '0;
            state_n    = RDATA;
          end else begin
            bit_cnt_n = bit_cnt + 5'd1;
            if (bit_cnt == 5'd1) begin
              bit_cnt_n = '0;
              state_n   = WDATA;
            end
          end
        end
        RDATA: begin
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == 5'd16) begin
            mdio_oe_n  = 1'b0;
            mdio_out_n = 1'b0;
            state_n    = IDLE;
          end else begin
            mdio_out_n = shreg[15];
            shreg_n    = {shreg[14:0], 1'b0};
          end
        end
        WDATA: begin
          reg_wdata_n = {reg_wdata[14:0], mdio_s};
          bit_cnt_n   = bit_cnt + 5'd1;
          if (bit_cnt == 5'd15) begin
            reg_wr_n = 1'b1;
            state_n  = IDLE;
          end
        end
        IGNORE: begin
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == 5'(IGNORE_EDGES - 1)) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end

    busy_n = (state_n == OPCODE) || (state_n == PHYAD) || (state_n == REGAD) ||
             (state_n == TA) || (state_n == RDATA) || (state_n == WDATA);
  end

  assign mdio_pin  = mdio_oe ? mdio_out : 1'bz;
  assign state_dbg = state;

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: frame table, register-strobe scoreboard, reset-mid-read sequence.
module tb_mdio_responder;
  import mdio_pkg::*;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam bit SUPPRESS = 1'b1;
`else
  localparam bit SUPPRESS = 1'b0;
`endif
  localparam int W = 22;

  logic        clock;
  logic        reset;
  logic        mdc;
  logic        tb_oe;
  logic        tb_out;
  wire         mdio;
  logic [4:0]  reg_addr;
  logic        reg_rd;
  logic [15:0] reg_rdata;
  logic        reg_wr;
  logic [15:0] reg_wdata;
  logic        busy;
  logic [3:0]  state_dbg;

  logic [15:0] mem [32];
  logic [W-1:0] exp_q[$];
  int checks;
  int errors;

  pullup (mdio);
  assign mdio = tb_oe ? tb_out : 1'bz;

  mdio_responder #(.PHY_ADDR(5'd1), .PREAMBLE_LEN(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .mdc_pin   (mdc),
    .mdio_pin  (mdio),
    .reg_addr  (reg_addr),
    .reg_rd    (reg_rd),
    .reg_rdata (reg_rdata),
    .reg_wr    (reg_wr),
    .reg_wdata (reg_wdata),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Register file model: data appears one clock after the read strobe.
  always @(posedge clock) begin
    if (reg_rd) reg_rdata <= mem[reg_addr];
  end

  // ---------------- scoreboard ----------------
  always @(negedge clock) begin
    if (reg_rd && reg_wr) begin
      checks++;
      errors++;
      $display("FAIL strobe_excl: got rd=1 wr=1 expected at most one");
    end else if (reg_rd || reg_wr) begin
      logic [W-1:0] act, expv;
      act = {reg_wr, reg_addr, reg_wr ? reg_wdata : 16'h0000};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: got %h expected none", act);
      end else begin
        expv = exp_q.pop_front();
        if (act !== expv) begin
          errors++;
          $display("FAIL strobe: got %h expected %h", act, expv);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b, input logic drive, output logic smp);
    @(negedge clock);
    tb_oe  = drive;
    tb_out = b;
    mdc    = 1'b0;
    repeat (4) @(negedge clock);
    mdc = 1'b1;
    repeat (5) @(negedge clock);
    smp = mdio;
  endtask

  task automatic send_header(input logic [1:0] op, input logic [4:0] phy,
                             input logic [4:0] ra, input int pre);
    logic s;
    if (!SUPPRESS) send_bit(1'b0, 1'b1, s);
    for (int i = 0; i < pre; i++) send_bit(1'b1, 1'b1, s);
    send_bit(1'b0, 1'b1, s);
    send_bit(1'b1, 1'b1, s);
    for (int i = 1; i >= 0; i--) send_bit(op[i], 1'b1, s);
    for (int i = 4; i >= 0; i--) send_bit(phy[i], 1'b1, s);
    for (int i = 4; i >= 0; i--) send_bit(ra[i], 1'b1, s);
  endtask

  task automatic run_frame(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                           input logic [15:0] data, input int pre, input logic hit);
    logic s;
    logic e;
    if (op == OP_READ) mem[ra] = data;
    if (hit) exp_q.push_back({op == OP_WRITE, ra, (op == OP_WRITE) ? data : 16'h0000});
    send_header(op, phy, ra, pre);
    check("busy_hdr", {31'd0, busy}, {31'd0, hit});
    if (op == OP_WRITE) begin
      send_bit(1'b1, 1'b1, s);
      send_bit(1'b0, 1'b1, s);
      for (int i = 15; i >= 0; i--) send_bit(data[i], 1'b1, s);
    end else begin
      for (int k = 0; k < 18; k++) begin
        send_bit(1'b1, 1'b0, s);
        if (!hit || k == 17) e = 1'b1;
        else if (k == 0) e = 1'b0;
        else e = data[16-k];
        check($sformatf("mdio_bit%0d", k), {31'd0, s}, {31'd0, e});
      end
    end
    check("state_end", {28'd0, state_dbg}, {28'd0, IDLE});
    check("busy_end", {31'd0, busy}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  ra;
    logic [15:0] data;
    int          pre;
    logic        hit;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic s;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    reg_rdata = 16'h0000;

    vecs[0] = '{OP_READ,  5'd1, 5'd2,  16'h0022, 32, 1'b1};
    vecs[1] = '{OP_WRITE, 5'd1, 5'd9,  16'h0200, 32, 1'b1};
    vecs[2] = '{OP_READ,  5'd3, 5'd2,  16'h0022, 32, 1'b0};
    vecs[3] = '{OP_READ,  5'd1, 5'd5,  16'hBEEF, 32, 1'b1};
    vecs[4] = '{OP_READ,  5'd1, 5'd2,  16'h0022, 31, SUPPRESS};
    vecs[5] = '{2'b11,    5'd1, 5'd4,  16'h0000, 32, 1'b0};
    vecs[6] = '{2'b00,    5'd1, 5'd4,  16'h0000, 32, 1'b0};
    vecs[7] = '{OP_WRITE, 5'd1, 5'd31, 16'hFFFF, 40, 1'b1};
    vecs[8] = '{OP_READ,  5'd1, 5'd0,  16'h8001, 32, 1'b1};
    vecs[9] = '{OP_WRITE, 5'd1, 5'd0,  16'h0001, 32, 1'b1};

    reset  = 1'b1;
    mdc    = 1'b0;
    tb_oe  = 1'b0;
    tb_out = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_state", {28'd0, state_dbg}, {28'd0, IDLE});
    check("rst_mdio", {31'd0, mdio}, 32'd1);
    check("rst_addr", {27'd0, reg_addr}, 32'd0);
    check("rst_wdata", {16'd0, reg_wdata}, 32'd0);
    check("rst_strobes", {30'd0, reg_rd, reg_wr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tb_oe = 1'b1;
    repeat (3) @(negedge clock);

    for (int i = 0; i < 10; i++)
      run_frame(vecs[i].op, vecs[i].phy, vecs[i].ra, vecs[i].data, vecs[i].pre, vecs[i].hit);

    for (int i = 0; i < 4; i++) begin
      logic [1:0]  op;
      logic [4:0]  ra;
      logic [15:0] d;
      op = ($urandom_range(0, 1) == 0) ? OP_READ : OP_WRITE;
      ra = 5'($urandom_range(0, 31));
      d  = 16'($urandom_range(0, 65535));
      run_frame(op, 5'd1, ra, d, 32, 1'b1);
    end

    // Reset in the middle of read data (after D8 is on the wire).
    mem[7] = 16'h1234;
    exp_q.push_back({1'b0, 5'd7, 16'h0000});
    send_header(OP_READ, 5'd1, 5'd7, 32);
    send_bit(1'b1, 1'b0, s);
    check("mr_ta", {31'd0, s}, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      send_bit(1'b1, 1'b0, s);
      check($sformatf("mr_bit%0d", 16 - k), {31'd0, s}, {31'd0, mem[7][16-k]});
    end
    check("mr_driving", {31'd0, mdio}, 32'd0);
    reset = 1'b1;
    #1;
    check("mr_release", {31'd0, mdio}, 32'd1);
    check("mr_state", {28'd0, state_dbg}, {28'd0, IDLE});
    check("mr_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    run_frame(OP_READ, 5'd1, 5'd7, 16'hA5A5, 32, 1'b1);

    repeat (10) @(negedge clock);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdio_responder.md
MDIO_RESPONDER -- requirements
Module: mdio_responder

Interface
REQ-001 SHALL have parameter PHY_ADDR, default 5'h00, the PHY address to which the block responds.
REQ-002 SHALL have parameter PREAMBLE_LEN, default 32, the number of consecutive ones required before ST.
REQ-003 clock  in  1  system clock; SHALL be at least 4x the MDC frequency.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 mdc_pin  in  1  management clock from the station.
REQ-006 mdio_pin  inout  1  management data; driven only during read TA bit 2 and read data, otherwise high-Z.
REQ-007 reg_addr  out  5  register address of the current frame.
REQ-008 reg_rd  out  1  one-clock read strobe.
REQ-009 reg_rdata  in  16  read data, valid one clock after reg_rd.
REQ-010 reg_wr  out  1  one-clock write strobe.
REQ-011 reg_wdata  out  16  write data, valid while reg_wr is high.
REQ-012 busy  out  1  high from a valid ST until the frame ends or is ignored.

Function
REQ-013 SHALL pass mdc_pin and mdio_pin through identical 2-FF synchronizers and act only on a detected MDC rising edge (mdc_s[1] & ~mdc_s[2]), sampling the synchronized mdio on that edge.
REQ-014 States SHALL be IDLE, START, OPCODE, PHYAD, REGAD, TA, RDATA, WDATA, IGNORE.
REQ-015 IDLE: count sampled ones, saturating at PREAMBLE_LEN; a sampled zero after the count reaches PREAMBLE_LEN SHALL enter START; a zero earlier SHALL clear the count.
REQ-016 START: a sampled 1 SHALL enter OPCODE; a 0 SHALL return to IDLE with the count cleared.
REQ-017 OPCODE: 2 bits, 10 = read, 01 = write; 00 or 11 SHALL enter IGNORE.
REQ-018 PHYAD: 5 bits, MSB first; a mismatch with PHY_ADDR SHALL enter IGNORE after the 5th bit.
REQ-019 REGAD: 5 bits, MSB first, loaded into reg_addr; for a read, reg_rd SHALL pulse on the clock after the 5th bit is sampled, and reg_rdata SHALL be captured into the shift register the following clock.
REQ-020 Read TA: on the edge sampling TA bit 1, mdio SHALL be driven 0; on each of the next 16 edges, the next data bit SHALL be driven MSB first; on the edge after D0 is driven, mdio SHALL be released and the state SHALL return to IDLE.
REQ-021 Write TA: 2 bits SHALL be sampled and ignored, then 16 bits shifted into reg_wdata; reg_wr SHALL pulse on the clock after the 16th bit is sampled, then the state SHALL return to IDLE.
REQ-022 IGNORE: 18 edges SHALL be consumed without driving mdio or issuing any strobe, then the state SHALL return to IDLE.
REQ-023 The preamble count SHALL restart at zero on every return to IDLE.
REQ-024 reg_rd and reg_wr SHALL never be high in the same clock, and each SHALL pulse at most once per frame.

Reset
REQ-025 Reset SHALL asynchronously set state = IDLE, preamble count = 0, mdio high-Z, reg_addr = 0, reg_wdata = 0, reg_rd = 0, reg_wr = 0, busy = 0.
REQ-026 Reset asserted mid-frame SHALL release mdio_pin in the same clock, and the next complete frame SHALL decode normally.

Configuration
REQ-027 With MDIO_PREAMBLE_SUPPRESS_EN defined, the block SHALL accept ST after a single sampled one following the end of the previous frame or reset; without it, PREAMBLE_LEN ones SHALL be required.

Structure
REQ-028 Package mdio_pkg SHALL hold the opcode constants (OP_READ = 2'b10, OP_WRITE = 2'b01), the state enumeration and the field widths.
REQ-029 The synchronizer and edge detector SHALL be sub-module mdio_sync.

Verification
REQ-030 PHY_ADDR = 1, read PHYAD 1, REGAD 0x02, reg_rdata = 16'h0022 -> one reg_rd pulse with reg_addr = 2; TA bit 2 = 0; mdio = 0x0022 MSB first; then high-Z.
REQ-031 Write PHYAD 1, REGAD 0x09, data 16'h0200 -> exactly one reg_wr pulse with reg_addr = 9 and reg_wdata = 16'h0200.
REQ-032 Read to PHYAD 3 with PHY_ADDR = 1 -> no strobes, mdio never driven, and a following valid frame is decoded.
REQ-033 Read preceded by only 31 ones -> ignored without the macro; decoded with MDIO_PREAMBLE_SUPPRESS_EN.
REQ-034 Opcode 11 -> no strobes, mdio never driven.
REQ-035 Reset during read data bit 8 -> mdio high-Z in the same clock; the next read of 16'hA5A5 returns the correct data.
